// File: rtl/gamma_lut_ctrl.sv
// Programmable gamma stage: double-banked LUT, host loads the shadow bank, banks swap only at frame boundaries.
// Optional feature: define GAMMA_BYPASS_EN to add a per-pixel bypass input.
module gamma_lut_ctrl #(
  parameter int COLOR_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COLOR_DEPTH-1:0] pixel_in,
  input  logic                   valid_in,
  input  logic [2:0]             color_in,
  input  logic                   last_pic_in,
  input  logic                   frame_end_in,
  input  logic                   cfg_we,
  input  logic [COLOR_DEPTH-1:0] cfg_addr,
  input  logic [COLOR_DEPTH-1:0] cfg_data,
  input  logic                   cfg_commit,
`ifdef GAMMA_BYPASS_EN
  input  logic                   bypass,
`endif
  output logic                   cfg_ready,
  output logic                   lut_loaded,
  output logic [COLOR_DEPTH-1:0] pixel_out,
  output logic                   valid_out,
  output logic [2:0]             color_out,
  output logic                   last_pic_out
);

  localparam int DEPTH = 1 << COLOR_DEPTH;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   active_bank_q, active_bank_d;
  logic   lut_loaded_q, lut_loaded_d;
  logic   frame_active_q, frame_active_d;
  logic   cfg_ready_q, cfg_ready_d;

  logic [COLOR_DEPTH-1:0] s1_pixel_q, s1_pixel_d;
  logic                   s1_valid_q, s1_valid_d;
  logic [2:0]             s1_color_q, s1_color_d;
  logic                   s1_last_q, s1_last_d;
  logic                   s1_bank_q, s1_bank_d;
  logic                   s1_ident_q, s1_ident_d;

  logic [COLOR_DEPTH-1:0] pixel_out_q, pixel_out_d;
  logic                   valid_out_q, valid_out_d;
  logic [2:0]             color_out_q, color_out_d;
  logic                   last_pic_out_q, last_pic_out_d;

  logic [COLOR_DEPTH-1:0] bank0_mem [DEPTH];
  logic [COLOR_DEPTH-1:0] bank1_mem [DEPTH];
  logic [COLOR_DEPTH-1:0] lut_rd;
  logic                   shadow_we;
  logic                   bank0_we;
  logic                   bank1_we;
  logic                   swap_ok;
  logic                   bypass_act;

`ifdef GAMMA_BYPASS_EN
  assign bypass_act = bypass;
`else
  assign bypass_act = 1'b0;
`endif

  // A swap edge is either a gap between frames or the last pixel of a frame;
  // that last pixel was already captured with the old bank.
  assign swap_ok = (!frame_active_q && !valid_in) || (valid_in && frame_end_in);

  always_comb begin
    state_d        = state_q;
    active_bank_d  = active_bank_q;
    lut_loaded_d   = lut_loaded_q;
    frame_active_d = valid_in ? !frame_end_in : frame_active_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_commit) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (swap_ok) begin
          state_d       = ST_IDLE;
          active_bank_d = !active_bank_q;
          lut_loaded_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cfg_ready_d = (state_d == ST_IDLE);
  end

  // Shadow bank is always the one not selected for reads.
  assign shadow_we = cfg_we && cfg_ready_q && !rst;
  assign bank0_we  = shadow_we && active_bank_q;
  assign bank1_we  = shadow_we && !active_bank_q;

  always_comb begin
    s1_pixel_d = pixel_in;
    s1_valid_d = valid_in;
    s1_color_d = color_in;
    s1_last_d  = last_pic_in;
    s1_bank_d  = active_bank_q;
    s1_ident_d = !lut_loaded_q || bypass_act;
  end

  always_comb begin
    lut_rd         = s1_bank_q ? bank1_mem[s1_pixel_q] : bank0_mem[s1_pixel_q];
    pixel_out_d    = s1_ident_q ? s1_pixel_q : lut_rd;
    valid_out_d    = s1_valid_q;
    color_out_d    = s1_color_q;
    last_pic_out_d = s1_last_q;
  end

  always_ff @(posedge clk) begin
    if (bank0_we) bank0_mem[cfg_addr] <= cfg_data;
    if (bank1_we) bank1_mem[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      active_bank_q  <= 1'b0;
      lut_loaded_q   <= 1'b0;
      frame_active_q <= 1'b0;
      cfg_ready_q    <= 1'b1;
      s1_pixel_q     <= '0;
      s1_valid_q     <= 1'b0;
      s1_color_q     <= '0;
      s1_last_q      <= 1'b0;
      s1_bank_q      <= 1'b0;
      s1_ident_q     <= 1'b1;
      pixel_out_q    <= '0;
      valid_out_q    <= 1'b0;
      color_out_q    <= '0;
      last_pic_out_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      active_bank_q  <= active_bank_d;
      lut_loaded_q   <= lut_loaded_d;
      frame_active_q <= frame_active_d;
      cfg_ready_q    <= cfg_ready_d;
      s1_pixel_q     <= s1_pixel_d;
      s1_valid_q     <= s1_valid_d;
      s1_color_q     <= s1_color_d;
      s1_last_q      <= s1_last_d;
      s1_bank_q      <= s1_bank_d;
      s1_ident_q     <= s1_ident_d;
      pixel_out_q    <= pixel_out_d;
      valid_out_q    <= valid_out_d;
      color_out_q    <= color_out_d;
      last_pic_out_q <= last_pic_out_d;
    end
  end

  assign cfg_ready    = cfg_ready_q;
  assign lut_loaded   = lut_loaded_q;
  assign pixel_out    = pixel_out_q;
  assign valid_out    = valid_out_q;
  assign color_out    = color_out_q;
  assign last_pic_out = last_pic_out_q;

endmodule

// File: doc/gamma_lut_ctrl.md
Name: gamma_lut_ctrl

Overview:
Programmable gamma stage with a host-loadable, double-banked lookup table. The host writes a new curve into the shadow bank while pixels stream through the active bank. A commit request swaps the banks only at a frame boundary, so no frame ever mixes two curves. The block sits in the pixel pipeline where a fixed gamma stage would sit, with the same pixel/valid/color/last_pic sideband and 2-cycle latency.

Parameters:
COLOR_DEPTH, 8, pixel width; each LUT bank has 2^COLOR_DEPTH entries of COLOR_DEPTH bits.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
pixel_in  in  COLOR_DEPTH  input pixel, also the LUT read address
valid_in  in  1  pixel_in qualifier
color_in  in  3  color tag, passed through
last_pic_in  in  1  last-picture flag, passed through
frame_end_in  in  1  marks the last pixel of a frame; meaningful only when valid_in=1
cfg_we  in  1  shadow-bank write strobe
cfg_addr  in  COLOR_DEPTH  shadow-bank write address
cfg_data  in  COLOR_DEPTH  shadow-bank write data
cfg_commit  in  1  single-cycle pulse requesting a bank swap
cfg_ready  out  1  1 = shadow bank writable and commit accepted
lut_loaded  out  1  1 after the first completed swap
pixel_out  out  COLOR_DEPTH  gamma-mapped pixel
valid_out  out  1  pixel_out qualifier
color_out  out  3  delayed color_in
last_pic_out  out  1  delayed last_pic_in

Behaviour:
- Reset values:
  - pixel_out=0, valid_out=0, color_out=0, last_pic_out=0.
  - cfg_ready=1, lut_loaded=0.
  - active_bank=0, state=IDLE, frame_active=0.
  - LUT RAM contents are not reset.
- Pipeline:
  - Stage 1 registers pixel_in, valid_in, color_in, last_pic_in and frame_end_in. It also captures the bank select in use that cycle.
  - Stage 2 registers the LUT read from the captured bank.
  - Latency is exactly 2 cycles, throughput 1 pixel/cycle, no back-pressure.
  - Sideband signals are delayed by 2 cycles unchanged.
  - valid_out=0 cycles still carry their registered data; the bench ignores them.
- Identity mode: while lut_loaded=0, pixel_out equals the stage-1 pixel (identity curve) instead of the RAM read.
- Frame tracking:
  - frame_active is set on any valid_in=1 with frame_end_in=0.
  - It is cleared on valid_in=1 with frame_end_in=1.
  - A single-pixel frame (valid_in and frame_end_in both 1 while idle) leaves frame_active=0.
- Config writes:
  - When cfg_we=1 and cfg_ready=1, shadow[cfg_addr] is written with cfg_data.
  - When cfg_we=1 and cfg_ready=0, the write is dropped and the shadow bank is unchanged.
- States:
  - IDLE: cfg_ready=1. On cfg_commit=1, go to PENDING.
  - PENDING: cfg_ready=0; cfg_commit is ignored. The swap fires at the clock edge where either:
    - frame_active=0 and valid_in=0, or
    - valid_in=1 and frame_end_in=1. That pixel still uses the old bank.
  - On swap: active_bank toggles, lut_loaded goes to 1, state returns to IDLE.
- A commit arriving on the same cycle as a swap-qualifying condition does not swap that cycle. It enters PENDING and swaps at the earliest qualifying edge from the next cycle on.
- If valid_in=1 and frame_end_in=0 arrives while PENDING with frame_active=0, a new frame starts on the old bank. The swap waits for that frame's end.
- A cfg_we on the same cycle as cfg_commit (in IDLE) is performed.
- Pixels accepted on and after the swap edge's following cycle read the new bank. In-flight stage-2 reads complete from their captured bank.
- rst mid-frame or mid-PENDING:
  - Pipeline, state, frame_active and lut_loaded return to reset values; the output reverts to identity.
  - RAM contents are kept.
- Bank RAMs:
  - 1 write port (shadow) and 1 read port (active), inferred as registered-read RAM or flops.
  - Read and write never target the same bank.

Optional Feature:
GAMMA_BYPASS_EN:
- When defined, adds input bypass (1 bit). When bypass is 1 in stage 1, pixel_out equals the stage-1 pixel, with latency and sideband unchanged.
- bypass does not affect bank state, config writes or commits.
- When undefined, the port is absent and the mapping is always LUT or identity as above.

Test Plan:
- Reset, then stream pixels 0,1,255 with no commit -> pixel_out 0,1,255 two cycles later; lut_loaded=0.
- Write shadow[i]=255-i for all i, commit while idle -> swap the next cycle; lut_loaded=1; pixels 0,10,255 map to 255,245,0.
- Mid-frame commit of shadow[i]=i>>1:
  - the rest of the frame including the frame_end pixel (100) maps via the old curve (155);
  - the first pixel of the next frame (100) maps to 50;
  - cfg_ready=0 throughout PENDING.
- cfg_we while PENDING (addr 5, data 99) -> dropped; after the swap, the next loaded curve still has its written value at 5.
- Commit with valid_in=1 and frame_end_in=1 on the same cycle -> enters PENDING; swap on the next idle cycle.
- Assert rst mid-PENDING -> state IDLE, cfg_ready=1, lut_loaded=0, identity output, valid_out=0 the cycle after reset.
